// File: rtl/sect283k1_pkg.sv
// sect283k1 shared definitions.
// Holds the field size, the SEC 2 base point and group order (used by benches
// and models), the word-count helper for a given stream width, and the state
// encoding of the point-multiplier I/O front end.
package sect283k1_pkg;

  localparam int unsigned M = 283;

  // Base point and order, written at 288 bits (72 hex digits) and trimmed to M.
  localparam logic [287:0] GX_288 =
    288'h0503213F_78CA4488_3F1A3B81_62F188E5_53CD265F_23C1567A_16876913_B0C2AC24_58492836;
  localparam logic [287:0] GY_288 =
    288'h01CCDA38_0F1C9E31_8D90F95D_07E5426F_E87E45C0_E8184698_E4596236_4E341161_77DD2259;
  localparam logic [287:0] N_288 =
    288'h01FFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFE9AE_2ED07577_265DFF7F_94451E06_1E163C61;

  localparam logic [M-1:0] GX = GX_288[M-1:0];
  localparam logic [M-1:0] GY = GY_288[M-1:0];
  localparam logic [M-1:0] N  = N_288[M-1:0];

  // Number of dw-bit words needed to carry one M-bit field element.
  function automatic int unsigned words_for(input int unsigned dw);
    return (M + dw - 1) / dw;
  endfunction

  localparam int unsigned NW = words_for(32);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_START  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_UNLOAD = 2'd3
  } state_e;

endpackage

// File: rtl/sect283k1_word_pack.sv
// Parallel-load, word-shift buffer of NWORDS words of DW bits.
// load_i captures data_i whole; shift_i moves the buffer down one word so that
// word_o always presents the next word to send (word 0 first).
// Ports: clk, rst_n, load_i, data_i[NWORDS*DW], shift_i, word_o[DW].
module sect283k1_word_pack #(
  parameter int unsigned DW     = 32,
  parameter int unsigned NWORDS = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic [NWORDS*DW-1:0] data_i,
  input  logic                 shift_i,
  output logic [DW-1:0]        word_o
);

  logic [NWORDS*DW-1:0] buf_q, buf_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    buf_d = buf_q;
    if (load_i) begin
      buf_d = data_i;
    end else if (shift_i) begin
      buf_d = {{DW{1'b0}}, buf_q[NWORDS*DW-1:DW]};
    end
  end

  // NOTE: this wide buffer is still reset to zero because the outputs it
  // feeds have defined reset values; flops stay flops, not a RAM.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
    end else begin
      buf_q <= buf_d;
    end
  end

  assign word_o = buf_q[DW-1:0];

endmodule

// File: rtl/sect283k1_pt_mul_io.sv
// Stream front/back end for the sect283k1 point multiplier core.
// Collects the scalar d from a DW-bit valid/ready write stream (LS word first),
// pulses core_start, waits for core_done, captures x and y and streams them out
// on a DW-bit valid/ready read stream: x words then y words, LS word first.
// Ports: clk, rst_n, clr (sync abort); in_valid/in_ready/in_data (scalar in);
// out_valid/out_ready/out_data/out_last (result out); busy; core_clr,
// core_start, core_d, core_done, core_x, core_y (core side).
module sect283k1_pt_mul_io
  import sect283k1_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          core_clr,
  output logic          core_start,
  output logic [M-1:0]  core_d,
  input  logic          core_done,
  input  logic [M-1:0]  core_x,
  input  logic [M-1:0]  core_y
);

  localparam int unsigned NWL = words_for(DW);
  localparam int unsigned BW  = NWL * DW;
  localparam int unsigned CW  = $clog2(2 * NWL);
  localparam logic [CW-1:0] IN_LAST  = CW'(NWL - 1);
  localparam logic [CW-1:0] OUT_LAST = CW'(2 * NWL - 1);

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;      // k while loading, j while unloading
  logic [(NWL-1)*DW-1:0]  stage_q, stage_d;  // scalar words 0..NWL-2
  logic [M-1:0]           d_q, d_d;          // committed scalar driven to the core
  logic                   run_q;             // low only until the first edge out of reset
  logic                   in_hs, out_hs, buf_load, buf_shift;
  logic [DW-1:0]          buf_word;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    busy       = 1'b0;
    core_start = 1'b0;
    in_hs      = 1'b0;
    out_hs     = 1'b0;
    buf_load   = 1'b0;
    buf_shift  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        in_ready = run_q;
        in_hs    = in_valid & run_q;
        if (in_hs) begin
          if (cnt_q == IN_LAST) begin
            cnt_d   = '0;
            state_d = ST_START;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_START: begin
        core_start = 1'b1;
        busy       = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (core_done) begin
          buf_load = 1'b1;
          state_d  = ST_UNLOAD;
        end
      end
      ST_UNLOAD: begin
        out_valid = 1'b1;
        out_last  = (cnt_q == OUT_LAST);
        out_hs    = out_ready;
        if (out_hs) begin
          buf_shift = 1'b1;
          if (out_last) begin
            cnt_d   = '0;
            state_d = ST_LOAD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
    // Abort wins over everything; a word handshaken in this cycle is dropped.
    if (clr) begin
      state_d   = ST_LOAD;
      cnt_d     = '0;
      in_hs     = 1'b0;
      out_hs    = 1'b0;
      buf_load  = 1'b0;
      buf_shift = 1'b0;
    end
  end

  // Early words wait in the staging register; the final word commits the whole
  // scalar at once so core_d never shows a half-loaded value. The truncating
  // cast drops the bits of the last word that lie above bit M-1.
  always_comb begin
    stage_d = stage_q;
    d_d     = d_q;
    if (in_hs) begin
      if (cnt_q == IN_LAST) begin
        d_d = M'({in_data, stage_q});
      end else begin
        stage_d[cnt_q*DW +: DW] = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      stage_q <= '0;
      d_q     <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      d_q     <= d_d;
      run_q   <= 1'b1;
    end
  end

  // Each element is zero-padded to a whole number of words: x low, y high.
  sect283k1_word_pack #(
    .DW     (DW),
    .NWORDS (2 * NWL)
  ) u_pack (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (buf_load),
    .data_i  ({BW'(core_y), BW'(core_x)}),
    .shift_i (buf_shift),
    .word_o  (buf_word)
  );

  assign core_clr = clr;
  assign core_d   = d_q;
  assign out_data = (state_q == ST_UNLOAD) ? buf_word : '0;

endmodule

// File: tb/tb_sect283k1_pt_mul_io.sv
// Directed bench for sect283k1_pt_mul_io with a behavioural core stub.
// Stub: core_done rises 5 cycles after core_start; mode 0 returns the base
// point when d==1, mode 1 returns x=0x1234 / y=all ones, mode 2 returns junk
// values used to show that stray done pulses are ignored.
module tb_sect283k1_pt_mul_io;
  import sect283k1_pkg::*;

  localparam int DW  = 32;
  localparam int NWT = 9;

  logic          clk, rst_n, clr;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready, out_last, busy;
  logic [DW-1:0] out_data;
  logic          core_clr, core_start, core_done;
  logic [M-1:0]  core_d, core_x, core_y;

  int n_checks = 0;
  int n_errors = 0;
  int start_cnt = 0;
  int hs_cnt = 0;

  logic [DW-1:0] scalar_w [0:NWT-1];
  logic [DW-1:0] exp_w    [0:2*NWT-1];

  sect283k1_pt_mul_io #(.DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .core_clr   (core_clr),
    .core_start (core_start),
    .core_d     (core_d),
    .core_done  (core_done),
    .core_x     (core_x),
    .core_y     (core_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- core stub ----------------
  logic [2:0]   stub_cnt;
  logic         stub_done, spur;
  logic [M-1:0] stub_d;
  int           mode;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_cnt  <= '0;
      stub_done <= 1'b0;
      stub_d    <= '0;
    end else begin
      stub_done <= 1'b0;
      if (core_clr) begin
        stub_cnt <= '0;
      end else if (core_start) begin
        stub_cnt <= 3'd5;
        stub_d   <= core_d;
      end else if (stub_cnt != 0) begin
        stub_cnt <= stub_cnt - 3'd1;
        if (stub_cnt == 3'd1) stub_done <= 1'b1;
      end
    end
  end

  assign core_done = stub_done | spur;

  always_comb begin
    core_x = '0;
    core_y = '0;
    case (mode)
      0: begin
        core_x = (stub_d == M'(1)) ? GX : '0;
        core_y = (stub_d == M'(1)) ? GY : '0;
      end
      1: begin
        core_x = M'(32'h0000_1234);
        core_y = '1;
      end
      default: begin
        core_x = M'(32'h0000_DEAD);
        core_y = M'(32'h0000_BEEF);
      end
    endcase
  end

  always @(negedge clk) if (core_start) start_cnt++;
  always @(posedge clk) if (rst_n && in_valid && in_ready) hs_cnt++;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_exp_gxy();
    logic [287:0] px, py;
    px = {5'b0, GX};
    py = {5'b0, GY};
    for (int k = 0; k < NWT; k++) begin
      exp_w[k]       = px[k*32 +: 32];
      exp_w[k + NWT] = py[k*32 +: 32];
    end
  endtask

  task automatic set_exp_stub();
    exp_w[0] = 32'h0000_1234;
    for (int k = 1; k < NWT; k++) exp_w[k] = 32'h0;
    for (int k = NWT; k < 2*NWT-1; k++) exp_w[k] = 32'hFFFF_FFFF;
    exp_w[2*NWT-1] = 32'h07FF_FFFF;
  endtask

  task automatic set_scalar_one();
    scalar_w[0] = 32'd1;
    for (int k = 1; k < NWT; k++) scalar_w[k] = 32'd0;
  endtask

  // Presents scalar_w; returns on the negedge after the last handshake.
  task automatic send_scalar(input bit hold);
    int t;
    for (int k = 0; k < NWT; k++) begin
      in_valid = 1'b1;
      in_data  = scalar_w[k];
      t = 0;
      while (!in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) begin
        check("in_ready_timeout", in_ready, 1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_out_valid();
    int t;
    t = 0;
    while (!out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("out_valid_timeout", out_valid, 1);
  endtask

  // Consumes words first..last-1 against exp_w; toggle inserts a stall per word.
  task automatic collect(input int first, input int last, input bit toggle);
    for (int j = first; j < last; j++) begin
      wait_out_valid();
      check($sformatf("word%0d", j), out_data, exp_w[j]);
      check($sformatf("last%0d", j), out_last, (j == 2*NWT-1));
      check($sformatf("in_ready_unload%0d", j), in_ready, 0);
      if (toggle) begin
        out_ready = 1'b0;
        @(negedge clk);
        check($sformatf("stall_word%0d", j), out_data, exp_w[j]);
        check($sformatf("stall_last%0d", j), out_last, (j == 2*NWT-1));
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s0, h0, t;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; spur = 1'b0; mode = 0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_core_start", core_start, 0);
    check("rst_core_clr", core_clr, 0);
    check("rst_core_d_zero", (core_d == '0), 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("load_in_ready", in_ready, 1);

    // d=1 -> base point, one start pulse, 1-cycle latencies
    mode = 0;
    set_scalar_one();
    set_exp_gxy();
    s0 = start_cnt;
    send_scalar(0);
    check("start_latency", core_start, 1);
    check("busy_start", busy, 1);
    check("in_ready_start", in_ready, 0);
    t = 0;
    while (!core_done && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("core_done_seen", core_done, 1);
    check("out_valid_at_done", out_valid, 0);
    @(negedge clk);
    check("out_valid_after_done", out_valid, 1);
    collect(0, 2*NWT, 0);
    check("drained_out_valid", out_valid, 0);
    check("drained_in_ready", in_ready, 1);
    check("start_pulses", start_cnt - s0, 1);

    // Top word truncation, no extra handshake, stalled unload
    mode = 1;
    set_exp_stub();
    for (int k = 0; k < NWT-1; k++) scalar_w[k] = 32'hA5A5_0000 + k;
    scalar_w[NWT-1] = 32'hFFFF_FFFF;
    h0 = hs_cnt;
    send_scalar(1);
    check("d_top_bits", core_d[282:256], 27'h7FF_FFFF);
    check("d_word0", core_d[31:0], 32'hA5A5_0000);
    check("d_word7", core_d[255:224], 32'hA5A5_0007);
    repeat (2) @(negedge clk);
    check("no_extra_hs", hs_cnt - h0, NWT);
    in_valid = 1'b0;
    collect(0, 2*NWT, 1);
    check("stub_drained", out_valid, 0);

    // clr in WAIT
    send_scalar(0);
    @(negedge clk);
    clr = 1'b1;
    #1;
    check("clr_wait_core_clr", core_clr, 1);
    @(negedge clk);
    clr = 1'b0;
    check("clr_wait_out_valid", out_valid, 0);
    check("clr_wait_in_ready", in_ready, 1);
    check("clr_wait_busy", busy, 0);
    repeat (8) @(negedge clk);
    check("clr_wait_no_result", out_valid, 0);

    // clr in UNLOAD at word 5, coincident with a handshake
    send_scalar(0);
    collect(0, 5, 0);
    wait_out_valid();
    out_ready = 1'b1;
    clr = 1'b1;
    #1;
    check("clr_unl_core_clr", core_clr, 1);
    @(negedge clk);
    clr = 1'b0;
    out_ready = 1'b0;
    check("clr_unl_out_valid", out_valid, 0);
    check("clr_unl_in_ready", in_ready, 1);
    check("clr_unl_out_data", out_data, 0);

    // Full run after the aborts
    mode = 0;
    set_scalar_one();
    set_exp_gxy();
    send_scalar(0);
    collect(0, 2*NWT, 0);
    check("post_clr_drained", out_valid, 0);

    // Stray done in LOAD
    mode = 2;
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    check("spur_load_out_valid", out_valid, 0);
    check("spur_load_out_data", out_data, 0);
    check("spur_load_busy", busy, 0);
    check("spur_load_in_ready", in_ready, 1);

    // Stray done in UNLOAD during a stall
    mode = 1;
    set_exp_stub();
    send_scalar(0);
    collect(0, 3, 0);
    wait_out_valid();
    mode = 2;
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    check("spur_unl_out_valid", out_valid, 1);
    check("spur_unl_out_data", out_data, exp_w[3]);
    collect(3, 2*NWT, 0);

    // Async reset mid-unload
    mode = 1;
    send_scalar(0);
    collect(0, 4, 0);
    wait_out_valid();
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_busy", busy, 0);
    check("arst_out_data", out_data, 0);
    check("arst_out_last", out_last, 0);
    check("arst_core_d_zero", (core_d == '0), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_release_in_ready", in_ready, 1);

    // in_valid held across back-to-back operations
    mode = 0;
    set_scalar_one();
    set_exp_gxy();
    h0 = hs_cnt;
    send_scalar(1);
    collect(0, 2*NWT, 0);
    check("b2b_first_hs", hs_cnt - h0, NWT);
    check("b2b_ready_after_last", in_ready, 1);
    send_scalar(0);
    check("b2b_second_hs", hs_cnt - h0, 2*NWT);
    collect(0, 2*NWT, 0);
    check("b2b_drained", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1);
  end

endmodule
